// File: rtl/pixel_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_streamer
//  Description : Double-buffered image front-end for layer_top. The host
//                fills the free bank with N_PIXELS pixels and commits it with
//                load_done. The block then pulses layer_start, holds d_out at
//                zero for STARTUP_DELAY cycles and streams one pixel per cycle.
//                The bank is released when layer_done is seen, so the host
//                can load image N+1 while image N is being classified.
//  Ports       : clk, rst (async, active-high)
//                wr_en/wr_addr/wr_data : host pixel writes into write bank
//                load_done             : commit the write bank
//                ld_ready              : write bank is free
//                layer_start           : one-cycle start to layer_top
//                d_out/pix_valid       : registered pixel stream
//                layer_done            : completion from layer_top (level)
//                busy                  : FSM not idle
//                frames_done           : retired image count (wraps)
//                err_overflow          : sticky commit-while-full flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_streamer #(
    parameter int N_PIXELS      = 784,
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 10,
    parameter int STARTUP_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load_done,
    output logic              ld_ready,
    output logic              layer_start,
    output logic [DATA_W-1:0] d_out,
    output logic              pix_valid,
    input  logic              layer_done,
    output logic              busy,
    output logic [7:0]        frames_done,
    output logic              err_overflow
);

    localparam int                c_dly_w     = (STARTUP_DELAY < 1) ? 1 : $clog2(STARTUP_DELAY + 1);
    localparam int                c_mem_depth = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W:0]   c_n_pix     = (ADDR_W + 1)'(N_PIXELS);
    localparam logic [ADDR_W-1:0] c_last_pix  = ADDR_W'(N_PIXELS - 1);
    localparam logic [c_dly_w-1:0] c_dly_init = c_dly_w'(STARTUP_DELAY);
    localparam logic [c_dly_w-1:0] c_dly_one  = c_dly_w'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DELAY     = 3'd2,
        S_STREAM    = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [DATA_W-1:0] bank_mem [0:c_mem_depth-1];

    state_t              state_q,     state_d;
    logic [c_dly_w-1:0]  dly_cnt_q,   dly_cnt_d;
    logic [ADDR_W-1:0]   pix_cnt_q,   pix_cnt_d;
    logic                wr_bank_q,   wr_bank_d;
    logic                rd_bank_q,   rd_bank_d;
    logic [1:0]          full_q,      full_d;
    logic                ld_ready_q,  ld_ready_d;
    logic [DATA_W-1:0]   d_out_q,     d_out_d;
    logic                pix_valid_q, pix_valid_d;
    logic [7:0]          frames_q,    frames_d;
    logic                err_q,       err_d;

    logic                w_wr_accept;
    logic                w_commit;
    logic                w_retire;
    logic                w_fetch;
    logic [ADDR_W-1:0]   w_fetch_addr;
    logic [ADDR_W:0]     w_rd_index;

    assign w_wr_accept = wr_en && ld_ready_q && ({1'b0, wr_addr} < c_n_pix);
    assign w_commit    = load_done && ld_ready_q;
    assign w_retire    = (state_q == S_WAIT_DONE) && layer_done;

    // ------------------------------------------------------------------
    // FSM next state. The pixel read is issued one cycle before it must
    // appear on d_out, so the last DELAY cycle (or START when there is no
    // delay) fetches pixel 0 and each STREAM cycle fetches the next one.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        dly_cnt_d    = dly_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        w_fetch      = 1'b0;
        w_fetch_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                dly_cnt_d = c_dly_init;
                pix_cnt_d = '0;
                if (STARTUP_DELAY == 0) begin
                    state_d = S_STREAM;
                    w_fetch = 1'b1;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                dly_cnt_d = dly_cnt_q - c_dly_one;
                if (dly_cnt_q == c_dly_one) begin
                    state_d = S_STREAM;
                    w_fetch = 1'b1;
                end
            end
            S_STREAM: begin
                if (pix_cnt_q == c_last_pix) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    pix_cnt_d    = pix_cnt_q + 1'b1;
                    w_fetch      = 1'b1;
                    w_fetch_addr = pix_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (layer_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read path and bank bookkeeping. A commit and a retire always target
    // different banks (commit needs a free bank, retire a full one), so
    // both updates can be applied to the same next-state vector.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_index  = {rd_bank_q, w_fetch_addr};
        d_out_d     = w_fetch ? bank_mem[w_rd_index] : '0;
        pix_valid_d = w_fetch;

        full_d = full_q;
        if (w_retire) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (w_commit) begin
            full_d[wr_bank_q] = 1'b1;
        end
        wr_bank_d  = wr_bank_q ^ w_commit;
        rd_bank_d  = rd_bank_q ^ w_retire;
        ld_ready_d = ~full_d[wr_bank_d];
        frames_d   = w_retire ? frames_q + 8'd1 : frames_q;
        err_d      = err_q | (load_done & ~ld_ready_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dly_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            ld_ready_q  <= 1'b1;
            d_out_q     <= '0;
            pix_valid_q <= 1'b0;
            frames_q    <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            ld_ready_q  <= ld_ready_d;
            d_out_q     <= d_out_d;
            pix_valid_q <= pix_valid_d;
            frames_q    <= frames_d;
            err_q       <= err_d;
        end
    end

    // Pixel storage carries no reset; the full flags define bank validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            bank_mem[{wr_bank_q, wr_addr}] <= wr_data;
        end
    end

    assign ld_ready     = ld_ready_q;
    assign layer_start  = (state_q == S_START);
    assign busy         = (state_q != S_IDLE);
    assign d_out        = d_out_q;
    assign pix_valid    = pix_valid_q;
    assign frames_done  = frames_q;
    assign err_overflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_streamer
//  Description : Directed, self-checking bench for pixel_streamer. A default
//                instance covers load/stream/overflow/reset behaviour; a
//                small instance (16 pixels, no startup delay) covers the
//                256-image frame counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_streamer;

    localparam int N  = 784;
    localparam int D  = 2;
    localparam int SN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, load_done, layer_done;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        ld_ready, layer_start, pix_valid, busy, err_overflow;
    logic [15:0] d_out;
    logic [7:0]  frames_done;

    logic        s_wr_en, s_load_done, s_layer_done;
    logic [3:0]  s_wr_addr;
    logic [15:0] s_wr_data;
    logic        s_ld_ready, s_layer_start, s_pix_valid, s_busy, s_err_overflow;
    logic [15:0] s_d_out;
    logic [7:0]  s_frames_done;

    pixel_streamer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_done(load_done), .ld_ready(ld_ready), .layer_start(layer_start),
        .d_out(d_out), .pix_valid(pix_valid), .layer_done(layer_done), .busy(busy),
        .frames_done(frames_done), .err_overflow(err_overflow)
    );

    pixel_streamer #(.N_PIXELS(SN), .DATA_W(16), .ADDR_W(4), .STARTUP_DELAY(0)) dut_s (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .load_done(s_load_done), .ld_ready(s_ld_ready), .layer_start(s_layer_start),
        .d_out(s_d_out), .pix_valid(s_pix_valid), .layer_done(s_layer_done), .busy(s_busy),
        .frames_done(s_frames_done), .err_overflow(s_err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_mem [2][N];

    typedef struct {
        int          off;
        logic        st;
        logic        pv;
        logic [15:0] dv;
        logic        bz;
    } probe_t;
    probe_t probes [12];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wr(input int bank, input int addr, input logic [15:0] data, input bit keep);
        wr_en   = 1'b1;
        wr_addr = addr[9:0];
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (keep) exp_mem[bank][addr] = data;
    endtask

    task automatic commit();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic wait_start(input string nm, output int t0);
        for (int i = 0; i < 4000; i++) begin
            if (layer_start === 1'b1) break;
            tick();
        end
        t0 = cyc;
        check({nm, " start seen"}, layer_start, 1);
    endtask

    // Checks a whole frame (or up to pixel abort_at) against exp_mem[bank].
    task automatic check_frame(input int bank, input string nm, input int abort_at);
        int t0, bad, first;
        logic [15:0] got_v, exp_v;
        bad = 0; first = -1; got_v = '0; exp_v = '0;
        wait_start(nm, t0);
        if (layer_start !== 1'b1) return;
        for (int o = 1; o <= D; o++) begin
            tick();
            if (pix_valid !== 1'b0 || d_out !== 16'h0) bad++;
        end
        for (int k = 0; k < N; k++) begin
            tick();
            if (pix_valid !== 1'b1 || d_out !== exp_mem[bank][k]) begin
                if (first < 0) begin
                    first = k; got_v = d_out; exp_v = exp_mem[bank][k];
                end
                bad++;
            end
            if (k == abort_at) break;
        end
        if (abort_at < 0) begin
            tick();
            if (pix_valid !== 1'b0 || d_out !== 16'h0 || busy !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d bad cycles, first pixel %0d got %0h expected %0h",
                     nm, bad, first, got_v, exp_v);
        end
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, " ld_ready"},     ld_ready,     1);
        check({nm, " layer_start"},  layer_start,  0);
        check({nm, " d_out"},        d_out,        0);
        check({nm, " pix_valid"},    pix_valid,    0);
        check({nm, " busy"},         busy,         0);
        check({nm, " frames_done"},  frames_done,  0);
        check({nm, " err_overflow"}, err_overflow, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_ld, t0, starts, nbusy, s_bad, s_fbad;
        logic [15:0] v;

        // Key points of the first frame relative to its START cycle.
        probes[0]  = '{0,   1'b1, 1'b0, 16'h0000, 1'b1};
        probes[1]  = '{1,   1'b0, 1'b0, 16'h0000, 1'b1};
        probes[2]  = '{2,   1'b0, 1'b0, 16'h0000, 1'b1};
        probes[3]  = '{3,   1'b0, 1'b1, 16'h0000, 1'b1};
        probes[4]  = '{4,   1'b0, 1'b1, 16'h0001, 1'b1};
        probes[5]  = '{5,   1'b0, 1'b1, 16'h0002, 1'b1};
        probes[6]  = '{258, 1'b0, 1'b1, 16'h00FF, 1'b1};
        probes[7]  = '{403, 1'b0, 1'b1, 16'h0190, 1'b1};
        probes[8]  = '{785, 1'b0, 1'b1, 16'h030E, 1'b1};
        probes[9]  = '{786, 1'b0, 1'b1, 16'h030F, 1'b1};
        probes[10] = '{787, 1'b0, 1'b0, 16'h0000, 1'b1};
        probes[11] = '{800, 1'b0, 1'b0, 16'h0000, 1'b1};

        rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; load_done = 0; layer_done = 0;
        s_wr_en = 0; s_wr_addr = '0; s_wr_data = '0; s_load_done = 0; s_layer_done = 0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // ---- Image A: pixel k = k into bank 0 ----
        for (int k = 0; k < N; k++) wr(0, k, 16'(k), 1'b1);
        load_done = 1'b1; t_ld = cyc; tick(); load_done = 1'b0;
        check("ld_ready after A commit", ld_ready, 1);
        wait_start("A", t0);
        check("A start latency", 32'(t0 - t_ld), 2);
        for (int i = 0; i < 12; i++) begin
            while (cyc - t0 < probes[i].off) tick();
            check($sformatf("A probe %0d layer_start", probes[i].off), layer_start, probes[i].st);
            check($sformatf("A probe %0d pix_valid", probes[i].off),   pix_valid,   probes[i].pv);
            check($sformatf("A probe %0d d_out", probes[i].off),       d_out,       probes[i].dv);
            check($sformatf("A probe %0d busy", probes[i].off),        busy,        probes[i].bz);
        end

        // ---- Image B into bank 1 while A waits for done ----
        for (int k = 0; k < N; k++) wr(1, k, 16'(40000 - 37 * k), 1'b1);
        commit();
        check("ld_ready after B commit", ld_ready, 0);
        wr(0, 5, 16'hFFFF, 1'b0);
        wr(0, 6, 16'hEEEE, 1'b0);
        commit();
        check("err_overflow set", err_overflow, 1);
        check("ld_ready stays 0", ld_ready, 0);

        starts = 0; nbusy = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (layer_start === 1'b1) starts++;
            if (busy !== 1'b1) nbusy++;
        end
        check("no start while waiting done", starts, 0);
        check("busy held in WAIT_DONE", nbusy, 0);

        layer_done = 1'b1; tick(); layer_done = 1'b0;
        check("frames_done after A", frames_done, 1);
        check("idle after A done", busy, 0);
        check("ld_ready after A retired", ld_ready, 1);
        tick();
        check("B start after one idle", layer_start, 1);

        // ---- Stream B while loading image C (even addresses only) ----
        fork
            check_frame(1, "stream B", -1);
            begin
                for (int k = 0; k < N; k += 2) wr(0, k, 16'(32'h8000 | k), 1'b1);
                wr(0, 784,  16'h1234, 1'b0);
                wr(0, 1023, 16'h4321, 1'b0);
            end
        join

        // Commit C and retire B in the same cycle.
        load_done = 1'b1; layer_done = 1'b1; tick(); load_done = 1'b0; layer_done = 1'b0;
        check("frames_done after B", frames_done, 2);
        check("ld_ready after joint update", ld_ready, 1);
        check("idle after joint update", busy, 0);
        check("err_overflow sticky", err_overflow, 1);

        // ---- Stream C, reset at pixel 400 ----
        check_frame(0, "stream C to pixel 400", 400);
        rst = 1'b1;
        #1;
        check_reset_values("mid-stream reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---- Image D after reset ----
        for (int k = 0; k < N; k++) wr(0, k, 16'(32'hFFFF - 3 * k), 1'b1);
        commit();
        check_frame(0, "stream D", -1);
        check("frames_done before D done", frames_done, 0);
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        check("frames_done after D", frames_done, 1);

        // ---- 256 images on the small instance: frame counter wrap ----
        s_bad = 0; s_fbad = 0;
        for (int img = 0; img < 256; img++) begin
            for (int k = 0; k < SN; k++) begin
                s_wr_en = 1'b1; s_wr_addr = 4'(k); s_wr_data = 16'(img * 97 + k * 13 + 5);
                tick();
            end
            s_wr_en = 1'b0;
            s_load_done = 1'b1; tick(); s_load_done = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (s_layer_start === 1'b1) break;
                tick();
            end
            if (s_layer_start !== 1'b1) s_bad++;
            for (int k = 0; k < SN; k++) begin
                tick();
                v = 16'(img * 97 + k * 13 + 5);
                if (s_pix_valid !== 1'b1 || s_d_out !== v) s_bad++;
            end
            repeat (10) begin
                tick();
                if (s_pix_valid !== 1'b0 || s_d_out !== 16'h0) s_bad++;
            end
            s_layer_done = 1'b1; tick(); s_layer_done = 1'b0;
            if (s_frames_done !== 8'(img + 1)) s_fbad++;
            if (img == 254) check("small frames_done at 255", s_frames_done, 255);
        end
        check("small streams over 256 images", s_bad, 0);
        check("small frame count sequence", s_fbad, 0);
        check("small frames_done wrapped", s_frames_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
